// File: rtl/pe_last_row_softmax.sv
// Last-row systolic PE for softmax: buffers one row while tracking its max, publishes
// the max on the shared vertical bus via req/gnt, then drains (x - max) per element.
module pe_last_row_softmax #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned LANES    = 2,
  parameter int unsigned ROW_LEN  = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output logic [BITWIDTH-1:0]       vertical_bus,
  output logic                      vbus_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  output logic                      out_last
);

  localparam int unsigned BEATS = ROW_LEN / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = LANES * BITWIDTH;
  localparam logic [CW-1:0]       LAST_BEAT = CW'(BEATS - 1);
  localparam logic [BITWIDTH-1:0] MIN_VAL   = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PUBLISH = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                     state, state_nx;
  logic [CW-1:0]              wr_cnt, rd_cnt;
  logic signed [BITWIDTH-1:0] max_reg, beat_max;
  logic [DW-1:0]              row_buf [BEATS];
  logic [DW-1:0]              rd_word;
  logic [BITWIDTH:0]          diff;
  logic                       in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nx;
  end

  // Next state and control outputs
  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    bus_req      = 1'b0;
    vertical_bus = '0;
    vbus_valid   = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && (wr_cnt == LAST_BEAT)) state_nx = PUBLISH;
      end
      PUBLISH: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          vertical_bus = max_reg;
          vbus_valid   = 1'b1;
          state_nx     = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == LAST_BEAT);
        if (out_ready && (rd_cnt == LAST_BEAT)) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Running max over all lanes of the current beat
  always_comb begin
    beat_max = max_reg;
    for (int i = 0; i < int'(LANES); i++) begin
      if ($signed(in_data[i*BITWIDTH +: BITWIDTH]) > beat_max)
        beat_max = in_data[i*BITWIDTH +: BITWIDTH];
    end
  end

  // Counters and row max
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      max_reg <= MIN_VAL;
    end else begin
      if (in_fire) begin
        max_reg <= beat_max;
        wr_cnt  <= (wr_cnt == LAST_BEAT) ? '0 : wr_cnt + 1'b1;
      end
      if (out_fire) begin
        if (rd_cnt == LAST_BEAT) begin
          rd_cnt  <= '0;
          max_reg <= MIN_VAL;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Row buffer has no reset; contents are only read after a full row is written
  always_ff @(posedge clk) begin
    if (in_fire) row_buf[wr_cnt] <= in_data;
  end

  // x - max at one extra bit; a sign/overflow disagreement means the result fell below MIN_VAL
  always_comb begin
    rd_word  = row_buf[rd_cnt];
    out_data = '0;
    diff     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      diff = {rd_word[i*BITWIDTH + BITWIDTH - 1], rd_word[i*BITWIDTH +: BITWIDTH]}
           - {max_reg[BITWIDTH-1], max_reg};
      if (SATURATE && (diff[BITWIDTH] != diff[BITWIDTH-1]))
        out_data[i*BITWIDTH +: BITWIDTH] = MIN_VAL;
      else
        out_data[i*BITWIDTH +: BITWIDTH] = diff[BITWIDTH-1:0];
    end
  end

endmodule
